uart_cfg: RTL

UART_CFG -- requirements
Module: uart_cfg

---
 rtl/uart_cfg_pkg.sv | 32 +++
 rtl/uart_fifo.sv | 50 +++++
 rtl/uart_cfg.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_cfg_pkg.sv
// Shared state encodings, parity modes and frame-format decode for uart_cfg.
package uart_cfg_pkg;

    localparam int OVERSAMPLE = 16;

    // Tick counts within a bit, counted from zero.
    localparam logic [4:0] S_MID  = 5'(OVERSAMPLE / 2 - 1);
    localparam logic [4:0] S_BIT  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] S_BIT2 = 5'(2 * OVERSAMPLE - 1);

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    // Index of the last data bit: 5..8 bits map to 4..7.
    function automatic logic [2:0] dbits_last(input logic [1:0] dbits);
        return 3'd4 + {1'b0, dbits};
    endfunction

    function automatic logic [7:0] dbits_mask(input logic [1:0] dbits);
        return 8'hff >> (2'd3 - dbits);
    endfunction

    function automatic logic par_on(input logic [1:0] mode);
        return !(mode == PAR_NONE || mode == PAR_NONE_ALT);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead FIFO; head entry is visible on r_data while not empty.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] w_data,
    input  logic             rd,
    output logic [WIDTH-1:0] r_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      cnt;
    logic             do_wr, do_rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign do_rd = rd && !empty;
    // A full FIFO still accepts a write when a read frees the slot in the same cycle.
    assign do_wr = wr && (!full || rd);
    assign r_data = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_cfg.sv
// UART with runtime frame format (5-8 data bits, parity, 1/2 stop), 16x oversampling and RX/TX FIFOs.
module uart_cfg
    import uart_cfg_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_BITS   = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIV_BITS-1:0] divisor,
    input  logic [1:0]          cfg_dbits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    input  logic                rx,
    output logic                tx,
    input  logic [7:0]          w_data,
    input  logic                wr_uart,
    output logic                tx_full,
    output logic [7:0]          r_data,
    output logic [1:0]          r_err,
    input  logic                rd_uart,
    output logic                rx_empty,
    output logic                rx_overrun,
    input  logic                clr_overrun
);
    // ---------------- baud tick ----------------
    logic [DIV_BITS-1:0] bcnt;
    logic                tick;

    // >= rather than == so a divisor lowered below the running count still recovers.
    assign tick = (bcnt >= divisor);

    always_ff @(posedge clk) begin
        if (rst)       bcnt <= '0;
        else if (tick) bcnt <= '0;
        else           bcnt <= bcnt + 1'b1;
    end

    // ---------------- receiver ----------------
    rx_state_t  rx_state, rx_next;
    logic [4:0] rx_s;
    logic [2:0] rx_n, rx_last;
    logic [7:0] rx_data;
    logic [1:0] rx_par;
    logic       rx_stop2, rx_perr, rx_push, rx_full, rx_drop;
    logic [9:0] rx_q;

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        case (rx_state)
            RX_IDLE:   if (!rx) rx_next = RX_START;
            RX_START:  if (tick && rx_s == S_MID) rx_next = rx ? RX_IDLE : RX_DATA;
            RX_DATA:   if (tick && rx_s == S_BIT && rx_n == rx_last)
                           rx_next = par_on(rx_par) ? RX_PARITY : RX_STOP;
            RX_PARITY: if (tick && rx_s == S_BIT) rx_next = RX_STOP;
            RX_STOP: begin
                // Only the first stop bit is sampled; a second one is just waited out.
                if (tick && rx_s == S_BIT) rx_push = 1'b1;
                if (tick && rx_s == (rx_stop2 ? S_BIT2 : S_BIT)) rx_next = RX_IDLE;
            end
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s     <= '0;
            rx_n     <= '0;
            rx_last  <= '0;
            rx_data  <= '0;
            rx_par   <= PAR_NONE;
            rx_stop2 <= 1'b0;
            rx_perr  <= 1'b0;
        end else begin
            if (rx_next != rx_state || (rx_state == RX_DATA && tick && rx_s == S_BIT))
                rx_s <= '0;
            else if (tick && rx_state != RX_IDLE)
                rx_s <= rx_s + 1'b1;
            case (rx_state)
                RX_IDLE: if (!rx) begin
                    rx_last  <= dbits_last(cfg_dbits);
                    rx_par   <= cfg_parity;
                    rx_stop2 <= cfg_stop2;
                    rx_data  <= '0;
                    rx_n     <= '0;
                    rx_perr  <= 1'b0;
                end
                RX_DATA: if (tick && rx_s == S_BIT) begin
                    rx_data[rx_n] <= rx;
                    rx_n          <= rx_n + 1'b1;
                end
                RX_PARITY: if (tick && rx_s == S_BIT)
                    rx_perr <= rx ^ (^rx_data) ^ (rx_par == PAR_ODD);
                default: ;
            endcase
        end
    end

    // A simultaneous read makes room, so only an unread full FIFO drops the frame.
    assign rx_drop = rx_push && rx_full && !rd_uart;

    always_ff @(posedge clk) begin
        if (rst)              rx_overrun <= 1'b0;
        else if (rx_drop)     rx_overrun <= 1'b1;
        else if (clr_overrun) rx_overrun <= 1'b0;
    end

    uart_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr     (rx_push),
        .w_data ({~rx, rx_perr, rx_data}),
        .rd     (rd_uart),
        .r_data (rx_q),
        .empty  (rx_empty),
        .full   (rx_full)
    );

    assign r_err  = rx_q[9:8];
    assign r_data = rx_q[7:0];

    // ---------------- transmitter ----------------
    tx_state_t  tx_state, tx_next;
    logic [4:0] tx_s;
    logic [2:0] tx_n, tx_last;
    logic [7:0] tx_sh, tx_q;
    logic [1:0] tx_par;
    logic       tx_stop2, tx_pbit, tx_pop, tx_empty;

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        tx      = 1'b1;
        case (tx_state)
            TX_IDLE: if (!tx_empty) begin
                tx_next = TX_START;
                tx_pop  = 1'b1;
            end
            TX_START: begin
                tx = 1'b0;
                if (tick && tx_s == S_BIT) tx_next = TX_DATA;
            end
            TX_DATA: begin
                tx = tx_sh[0];
                if (tick && tx_s == S_BIT && tx_n == tx_last)
                    tx_next = par_on(tx_par) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                tx = tx_pbit;
                if (tick && tx_s == S_BIT) tx_next = TX_STOP;
            end
            TX_STOP: if (tick && tx_s == (tx_stop2 ? S_BIT2 : S_BIT)) begin
                // Back-to-back frames: go straight to the next start bit.
                if (!tx_empty) begin
                    tx_next = TX_START;
                    tx_pop  = 1'b1;
                end else begin
                    tx_next = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_s     <= '0;
            tx_n     <= '0;
            tx_last  <= '0;
            tx_sh    <= '0;
            tx_par   <= PAR_NONE;
            tx_stop2 <= 1'b0;
            tx_pbit  <= 1'b0;
        end else begin
            if (tx_next != tx_state || tx_pop || (tx_state == TX_DATA && tick && tx_s == S_BIT))
                tx_s <= '0;
            else if (tick && tx_state != TX_IDLE)
                tx_s <= tx_s + 1'b1;
            if (tx_pop) begin
                tx_sh    <= tx_q & dbits_mask(cfg_dbits);
                tx_pbit  <= (^(tx_q & dbits_mask(cfg_dbits))) ^ (cfg_parity == PAR_ODD);
                tx_last  <= dbits_last(cfg_dbits);
                tx_par   <= cfg_parity;
                tx_stop2 <= cfg_stop2;
                tx_n     <= '0;
            end else if (tx_state == TX_DATA && tick && tx_s == S_BIT) begin
                tx_sh <= tx_sh >> 1;
                tx_n  <= tx_n + 1'b1;
            end
        end
    end

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr_uart),
        .w_data (w_data),
        .rd     (tx_pop),
        .r_data (tx_q),
        .empty  (tx_empty),
        .full   (tx_full)
    );

endmodule
